// File: rtl/if_fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/grant port, decode handoff.
// master = fetch unit side (drives imem_req/imem_addr and the inst_* outputs).
// slave  = environment side (memory plus decode/branch logic).
interface if_fetch_if;
  // redirect from execute
  logic        redirect;
  logic [31:0] redirect_pc;
  // instruction memory request/grant, in-order responses
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  // decode handoff (valid/ready)
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: sequential word fetch over req/gnt, PC-tagged in-order buffer to decode.
// Latency: request one cycle after run/redirect; rvalid at edge N shows as inst_valid after N.
// Backpressure: outstanding + buffered capped at DEPTH; imem_req drops when the credit runs out.
// Ports: clk, reset_n (async active-low); bus (if_fetch_if.master) carries redirect,
//        imem_req/addr/gnt/rvalid/rdata and inst_valid/ready/inst/inst_pc.
module if_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  if_fetch_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t          fifo_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   kill_cnt;
  logic            run;
  logic [31:0]     fetch_pc;
  logic [31:0]     resp_pc;

  logic [CW:0]     credit_used;
  logic            req;
  logic            grant;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic            head_vld;
  logic [31:0]     target;
  logic            unused_bits;

  assign target      = {bus.redirect_pc[31:2], 2'b00};
  assign unused_bits = ^bus.redirect_pc[1:0];

  // Killed fetches still hold a credit until their response returns.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign req         = run && !bus.redirect && (credit_used < LIMIT);
  assign grant       = req && bus.imem_gnt;

  // An rvalid with nothing outstanding (e.g. a late response after reset) is ignored.
  assign rsp_ok      = bus.imem_rvalid && (outstanding != '0);
  assign push        = rsp_ok && (kill_cnt == '0) && !bus.redirect;
  assign head_vld    = (count != '0);
  assign pop         = head_vld && bus.inst_ready && !bus.redirect;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = head_vld;
  // Gated so the outputs read zero whenever the buffer is empty.
  assign bus.inst       = head_vld ? fifo_mem[rd_ptr].word : 32'h0;
  assign bus.inst_pc    = head_vld ? fifo_mem[rd_ptr].pc   : 32'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      fetch_pc    <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      outstanding <= '0;
      kill_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      run         <= 1'b1;
      // grant is forced low during redirect, so this holds in both branches
      outstanding <= outstanding + CW'(grant) - CW'(rsp_ok);
      if (bus.redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        // everything still in flight after this edge is stale
        kill_cnt <= outstanding - CW'(rsp_ok);
        rd_ptr   <= wr_ptr;
        count    <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + 1'b1;
        end
        if (rsp_ok && (kill_cnt != '0)) kill_cnt <= kill_cnt - 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: head outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {resp_pc, bus.imem_rdata};
  end
endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: memory model with configurable latency, scoreboard of
// expected {pc, inst} pushed at each grant, monitor popping at each decode handshake.
module tb_if_fetch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  if_fetch_if bus ();

  if_fetch #(.BOOT_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- memory model + scoreboard producer ----------------
  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

  pend_t pend [$];
  exp_t  exp_q [$];
  int    cyc = 0;
  int    lat = 1;
  logic  stray = 1'b0;
  int    grant_cnt = 0;

  initial begin : mem_model
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      if (!reset_n) pend.delete();
      if (stray) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pend[0].addr ^ 32'hA5A5_0000;
        void'(pend.pop_front());
      end
      if (reset_n && bus.imem_req && bus.imem_gnt) begin
        grant_cnt++;
        pend.push_back('{bus.imem_addr, cyc + lat});
        exp_q.push_back('{bus.imem_addr, bus.imem_addr ^ 32'hA5A5_0000});
        chk("credit_limit", {31'b0, exp_q.size() <= DEPTH}, 32'd1);
      end
    end
  end

  // ---------------- monitor / scoreboard consumer ----------------
  logic [31:0] got_pc [$];
  int          pops = 0;

  initial begin : monitor
    exp_t        e;
    logic        held;
    logic [31:0] hold_pc, hold_ins;
    held = 1'b0;
    hold_pc = 32'h0;
    hold_ins = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset_n || bus.redirect) begin
        held = 1'b0;
      end else begin
        if (held && bus.inst_valid) begin
          chk("hold_inst_pc", bus.inst_pc, hold_pc);
          chk("hold_inst", bus.inst, hold_ins);
        end
        held = 1'b0;
        if (bus.inst_valid && bus.inst_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst: got pc %h inst %h, expected nothing", bus.inst_pc, bus.inst);
          end else begin
            e = exp_q.pop_front();
            chk("inst_pc", bus.inst_pc, e.pc);
            chk("inst", bus.inst, e.ins);
          end
          got_pc.push_back(bus.inst_pc);
          pops++;
        end else if (bus.inst_valid) begin
          held = 1'b1;
          hold_pc = bus.inst_pc;
          hold_ins = bus.inst;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, {31'b0, bus.imem_req}, 32'd0);
    chk({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
    chk({tag, "_inst_valid"}, {31'b0, bus.inst_valid}, 32'd0);
    chk({tag, "_inst"}, bus.inst, 32'h0);
    chk({tag, "_inst_pc"}, bus.inst_pc, 32'h0);
  endtask

  // Asserts reset mid-cycle, checks the async clear, releases at posedge+1.
  task automatic apply_reset(input string tag);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs(tag);
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic chk_pc(input string name, input int idx, input logic [31:0] exp);
    if (idx < got_pc.size()) chk(name, got_pc[idx], exp);
    else begin
      checks++;
      errors++;
      $display("FAIL %s: got no instruction at index %0d, expected pc %h", name, idx, exp);
    end
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc);
    int start;
    int n;
    start = pops;
    n = 0;
    while (pops == start && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk_pc(name, start, exp_pc);
  endtask

  // ---------------- directed tests ----------------
  initial begin : stimulus
    int p0;
    int g0;
    logic [31:0] a;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_gnt    = 1'b1;
    bus.inst_ready  = 1'b1;

    // 1: reset state, then zero-wait streaming
    #1 reset_n = 1'b0;
    tick(2);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    #1 chk("req_before_run", {31'b0, bus.imem_req}, 32'd0);
    tick();
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    tick();
    chk("fill_valid_low", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    chk("fill_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("fill_pc", bus.inst_pc, 32'h0);
    chk("fill_inst", bus.inst, 32'hA5A5_0000);
    p0 = pops;
    tick(6);
    chk("throughput_pops", pops - p0, 32'd6);
    for (int i = 0; i < 6; i++) chk_pc("stream_pc", p0 + i, 32'(i * 4));

    // 2: decode stalled from reset: exactly DEPTH grants, then resume
    bus.inst_ready = 1'b0;
    apply_reset("stall_reset");
    g0 = grant_cnt;
    tick(12);
    chk("stall_grants", grant_cnt - g0, 32'd4);
    chk("stall_req", {31'b0, bus.imem_req}, 32'd0);
    chk("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("stall_pc", bus.inst_pc, 32'h0);
    chk("stall_inst", bus.inst, 32'hA5A5_0000);
    p0 = pops;
    bus.inst_ready = 1'b1;
    tick(8);
    for (int i = 0; i < 6; i++) chk_pc("resume_pc", p0 + i, 32'(i * 4));

    // 3: grant withheld for 5 cycles
    bus.imem_gnt = 1'b0;
    #1 a = bus.imem_addr;
    for (int i = 0; i < 5; i++) begin
      chk("gnt_low_req", {31'b0, bus.imem_req}, 32'd1);
      chk("gnt_low_addr", bus.imem_addr, a);
      tick();
    end
    g0 = grant_cnt;
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    tick();
    chk("one_grant", grant_cnt - g0, 32'd1);
    chk("addr_advance", bus.imem_addr, a + 32'd4);
    bus.imem_gnt = 1'b1;
    tick(4);

    // 4: redirect with two fetches outstanding, 3-cycle memory
    lat = 3;
    bus.imem_gnt = 1'b0;
    apply_reset("lat3_reset");
    tick(2);
    bus.imem_gnt = 1'b1;
    tick(2);
    bus.imem_gnt = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_1002;
    exp_q.delete();
    #1 chk("redir_req_low", {31'b0, bus.imem_req}, 32'd0);
    tick();
    bus.redirect = 1'b0;
    bus.imem_gnt = 1'b1;
    #1;
    chk("redir_new_req", {31'b0, bus.imem_req}, 32'd1);
    chk("redir_new_addr", bus.imem_addr, 32'h0000_1000);
    chk("no_stale_valid0", {31'b0, bus.inst_valid}, 32'd0);
    tick(2);
    chk("no_stale_valid2", {31'b0, bus.inst_valid}, 32'd0);
    wait_pop("redir_first_pc", 32'h0000_1000);
    tick(4);

    // back-to-back redirects: the second one wins
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_3000;
    exp_q.delete();
    tick();
    bus.redirect_pc = 32'h0000_3010;
    exp_q.delete();
    tick();
    bus.redirect = 1'b0;
    wait_pop("b2b_first_pc", 32'h0000_3010);
    tick(4);

    // 5: redirect coinciding with a pop and an arriving rvalid
    lat = 1;
    apply_reset("lat1_reset");
    tick(6);
    chk("pre_redir_valid", {31'b0, bus.inst_valid}, 32'd1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    exp_q.delete();
    tick();
    bus.redirect = 1'b0;
    chk("flush_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("flush_new_addr", bus.imem_addr, 32'h0000_2000);
    wait_pop("redir_pop_first_pc", 32'h0000_2000);
    tick(4);

    // 6: reset mid-stream with responses in flight, stray rvalids
    lat = 3;
    tick(8);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    stray = 1'b1;
    exp_q.delete();
    #1 chk_reset_outputs("midreset");
    tick(2);
    reset_n = 1'b1;
    tick();
    chk("restart_req", {31'b0, bus.imem_req}, 32'd1);
    chk("restart_addr", bus.imem_addr, 32'h0);
    tick();
    stray = 1'b0;
    wait_pop("restart_first_pc", 32'h0);
    tick(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit for the single-cycle/pipelined RISC-V core. It owns the sequential fetch address and issues word requests to instruction memory over a request/grant port. In-order responses are buffered with their PCs and handed to the decode stage over a valid/ready handshake. Branch/jump redirects flush all buffered and in-flight instructions.

## Interface
- `BOOT_ADDR`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 4: instruction buffer entries; power of two, ≥2; also the limit on outstanding plus buffered fetches.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `redirect` in 1: single-cycle pulse; flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch address; bits [1:0] ignored (forced 0).
- `imem_req` out 1: request valid.
- `imem_addr` out 32: word address of request (byte address, [1:0]=0).
- `imem_gnt` in 1: request accepted this cycle when `imem_req`=1.
- `imem_rvalid` in 1: read data valid, in grant order, ≥1 cycle after its grant.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: buffer head valid.
- `inst_ready` in 1: decode accepts head.
- `inst` out 32: head instruction.
- `inst_pc` out 32: PC of head instruction.

## Operation
- Registers: `fetch_pc`, `resp_pc`, `outstanding` (0..DEPTH), `kill_cnt` (0..DEPTH), `run` flag, DEPTH-entry FIFO of {pc, instruction}.
- `run` clears on reset and sets on the first rising edge with `reset_n`=1.
- `imem_req` = `run` && !`redirect` && (`outstanding` + fifo count < DEPTH). `imem_addr` = `fetch_pc`.
- Grant (`imem_req`&&`imem_gnt`): `fetch_pc` += 4 (wraps mod 2^32), `outstanding` +1.
- No grant: `imem_req` stays high and `imem_addr` remains stable until granted or redirected.
- Response (`imem_rvalid`): `outstanding` −1.
  - If `kill_cnt`>0: drop the data and decrement `kill_cnt`.
  - Otherwise push {`resp_pc`, `imem_rdata`} and advance `resp_pc` by 4.
  - The credit rule guarantees the FIFO never overflows; an rvalid with `outstanding`=0 is a protocol error and is ignored.
- Pop: `inst_valid`&&`inst_ready` removes the head.
- Simultaneous push and pop are both performed, count unchanged.
- Redirect cycle:
  - `fetch_pc` and `resp_pc` <= {`redirect_pc`[31:2],2'b00}.
  - FIFO emptied; any pop in the same cycle is ignored.
  - `imem_req` is low, so no grant can occur.
  - Any response arriving that cycle is dropped.
  - `kill_cnt` <= `outstanding` − `imem_rvalid` + (`kill_cnt` handling folded in: total in-flight after this cycle).
  - `outstanding` still counts killed fetches, so credit accounting includes them.
- Back-to-back redirects: each one retargets. `kill_cnt` always equals the remaining in-flight count.

## Timing
- Reset (async assert) values:
  - `imem_req`=0, `imem_addr`=BOOT_ADDR.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0.
  - All counters 0, `run`=0.
- After release, the first edge sets `run`. `imem_req`=1 with `imem_addr`=BOOT_ADDR in the following cycle.
- Latency: rvalid at edge N means the entry is written at N. `inst_valid` is visible after N; there is no combinational rvalid→`inst_valid` bypass.
- Zero-wait memory, `inst_ready`=1, DEPTH=4: one instruction per cycle sustained after a 2-cycle fill.
- Redirect at edge N: first request to the new target is in cycle N+1. Nothing older is ever presented after N.
- Reset mid-operation clears everything immediately. Late memory responses after reset are ignored (`outstanding`=0).
- Outputs `inst`/`inst_pc` hold their value while `inst_valid`=1 and `inst_ready`=0.

## Test plan
- Reset then zero-wait memory (gnt=1, rvalid next cycle, rdata=addr^32'hA5A5_0000), `inst_ready`=1:
  - `inst_pc` sequence 0,4,8,12,… on consecutive cycles.
  - `inst` matches rdata for each.
  - All outputs 0 during reset.
- `inst_ready`=0 with zero-wait memory:
  - Exactly DEPTH grants, then `imem_req`=0.
  - `inst` and `inst_pc` are stable.
  - Raising `inst_ready` resumes fetch without loss or duplication.
- `imem_gnt` held low 5 cycles:
  - `imem_req`=1 and `imem_addr` constant throughout.
  - Exactly one fetch occurs when gnt rises.
- Redirect to 32'h0000_1002 with 2 fetches outstanding (3-cycle memory latency):
  - Both stale responses are dropped.
  - Next `inst_pc`=32'h0000_1000.
  - No stale `inst_valid`.
- Redirect coinciding with pop and with an rvalid:
  - Neither the popped entry nor the arriving word reaches decode.
  - Credit accounting never exceeds DEPTH.
- Assert `reset_n`=0 mid-stream with responses in flight:
  - Outputs clear asynchronously.
  - After release, fetch restarts at BOOT_ADDR.
  - Stray rvalid pulses are ignored.
